// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [ADDR_W_DEF-1:0] SIM_END_WORD = 14'h3FFF;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [3:0]            be;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of DM grants taken while fetch waits; forces a fetch grant at the limit.
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!if_req || if_gnt) begin
      cnt <= '0;
    end else if (dm_gnt && (cnt != CNT_MAX)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign force_if = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch and load/store: data-first priority,
// fetch starvation guard, one access per cycle, read data routed back one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_do,
  output logic [DATA_W-1:0] sram_di
);

  logic              force_if;
  logic              any_gnt;
  logic              rd_gnt;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] di_q;
  logic              resp_valid;
  owner_e            resp_owner;

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt),
    .force_if(force_if)
  );

  // Grants are gated by reset so every output sits at its reset value while rst is high.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if_gnt = if_req && (!dm_req || force_if);
      dm_gnt = dm_req && !if_gnt;
    end
  end

  always_comb begin
    any_gnt  = if_gnt || dm_gnt;
    rd_gnt   = if_gnt || (dm_gnt && (dm_be == 4'h0));
    sram_cs  = any_gnt;
    sram_web = dm_gnt ? ~dm_be : 4'hF;
    sram_a   = a_q;
    sram_di  = di_q;
    if (any_gnt) begin
      sram_a  = if_gnt ? if_addr : dm_addr;
      sram_di = dm_wdata;
    end
  end

  // Last driven address/data are held so the SRAM bus stays quiet between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      di_q <= '0;
    end else if (any_gnt) begin
      a_q  <= sram_a;
      di_q <= sram_di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_owner <= OWN_IF;
    end else begin
      resp_valid <= rd_gnt;
      if (rd_gnt) begin
        resp_owner <= if_gnt ? OWN_IF : OWN_DM;
      end
    end
  end

  always_comb begin
    sram_oe   = resp_valid;
    if_rvalid = resp_valid && (resp_owner == OWN_IF);
    dm_rvalid = resp_valid && (resp_owner == OWN_DM);
    if_rdata  = if_rvalid ? sram_do : '0;
    dm_rdata  = dm_rvalid ? sram_do : '0;
  end

endmodule
